axi4_cpu_port_arbiter: RTL and testbench



---
 rtl/axi4_pkg.sv | 7 +
 rtl/axi4_if.sv | 76 +++++++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/axi4_cpu_port_arbiter.sv | 130 +++++++++++++
 tb/tb_axi4_cpu_port_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared helpers and types for the CPU-side AXI4 port arbiter
package axi4_pkg;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_DATA = 1'b1} wr_state_e;
endpackage

// File: rtl/axi4_if.sv
// axi4_if: full AXI4 bundle with master/slave views
interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int USER_W = 1
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;
    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;
    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter whose grant stays pinned while a handshake is stalled
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    input  logic          i_adv,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_hold_idx;
    logic          r_hold;
    logic [IW-1:0] w_rr_idx;
    logic [IW-1:0] w_j;
    logic          w_found;
    // first requester strictly after the pointer, wrapping at N
    always_comb begin
        w_rr_idx = '0;
        w_found  = 1'b0;
        w_j      = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_j = (w_j == IW'(N - 1)) ? '0 : w_j + IW'(1);
            if (!w_found && i_req[w_j]) begin
                w_found  = 1'b1;
                w_rr_idx = w_j;
            end
        end
    end
    assign o_idx = r_hold ? r_hold_idx : w_rr_idx;
    assign o_gnt = i_en ? ((N'(1) << o_idx) & i_req) : '0;
    // pointer follows the last winner; a stalled grant is remembered so payload stays stable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= IW'(N - 1);
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            r_hold     <= |o_gnt && !i_adv;
            r_hold_idx <= o_idx;
            if (i_adv) r_ptr <= o_idx;
        end
    end
endmodule

// File: rtl/axi4_cpu_port_arbiter.sv
// axi4_cpu_port_arbiter: merges N upstream AXI4 masters into one downstream master with ID-prefix routing
module axi4_cpu_port_arbiter
    import axi4_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_USER_WIDTH  = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    axi4_if.Slave S_AXI [N_PORTS],
    axi4_if.Master M_AXI
);
    localparam int IDX_W = idx_w(N_PORTS);
    localparam int PL_W  = AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
    localparam int WP_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + AXI_USER_WIDTH + 1;
    logic [N_PORTS-1:0]      w_ar_req, w_aw_req, w_ar_gnt, w_aw_gnt, w_w_vld;
    logic [AXI_ID_WIDTH-1:0] w_ar_id [N_PORTS];
    logic [AXI_ID_WIDTH-1:0] w_aw_id [N_PORTS];
    logic [PL_W-1:0]         w_ar_pl [N_PORTS];
    logic [PL_W-1:0]         w_aw_pl [N_PORTS];
    logic [WP_W-1:0]         w_w_pl  [N_PORTS];
    logic [IDX_W-1:0]        w_ar_idx, w_aw_idx, w_w_idx, w_r_dst, w_b_dst;
    logic [(1<<IDX_W)-1:0]   w_r_rdy, w_b_rdy;
    logic                    w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs, w_w_open;
    logic [3:0]              r_ar_cnt, r_aw_cnt;
    logic [IDX_W-1:0]        r_w_owner;
    wr_state_e               r_wstate;
    logic                    r_route_err;
    assign w_r_dst = M_AXI.r_id[AXI_ID_WIDTH +: IDX_W];
    assign w_b_dst = M_AXI.b_id[AXI_ID_WIDTH +: IDX_W];
    assign w_w_idx  = (r_wstate == WR_DATA) ? r_w_owner : w_aw_idx;
    assign w_w_open = (r_wstate == WR_DATA) || M_AXI.aw_valid;
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign w_ar_req[i]       = S_AXI[i].ar_valid;
        assign w_ar_id[i]        = S_AXI[i].ar_id;
        assign w_ar_pl[i]        = {S_AXI[i].ar_addr, S_AXI[i].ar_len, S_AXI[i].ar_size, S_AXI[i].ar_burst, S_AXI[i].ar_lock,
                                    S_AXI[i].ar_cache, S_AXI[i].ar_prot, S_AXI[i].ar_qos, S_AXI[i].ar_region, S_AXI[i].ar_user};
        assign S_AXI[i].ar_ready = w_ar_gnt[i] && M_AXI.ar_ready;
        assign w_aw_req[i]       = S_AXI[i].aw_valid;
        assign w_aw_id[i]        = S_AXI[i].aw_id;
        assign w_aw_pl[i]        = {S_AXI[i].aw_addr, S_AXI[i].aw_len, S_AXI[i].aw_size, S_AXI[i].aw_burst, S_AXI[i].aw_lock,
                                    S_AXI[i].aw_cache, S_AXI[i].aw_prot, S_AXI[i].aw_qos, S_AXI[i].aw_region, S_AXI[i].aw_user};
        assign S_AXI[i].aw_ready = w_aw_gnt[i] && M_AXI.aw_ready;
        assign w_w_vld[i]        = S_AXI[i].w_valid;
        assign w_w_pl[i]         = {S_AXI[i].w_data, S_AXI[i].w_strb, S_AXI[i].w_user, S_AXI[i].w_last};
        assign S_AXI[i].w_ready  = w_w_open && (w_w_idx == IDX_W'(i)) && M_AXI.w_ready;
        assign S_AXI[i].r_valid  = !i_rst && M_AXI.r_valid && (w_r_dst == IDX_W'(i));
        assign S_AXI[i].r_id     = M_AXI.r_id[AXI_ID_WIDTH-1:0];
        assign S_AXI[i].r_data   = M_AXI.r_data;
        assign S_AXI[i].r_resp   = M_AXI.r_resp;
        assign S_AXI[i].r_last   = M_AXI.r_last;
        assign S_AXI[i].r_user   = M_AXI.r_user;
        assign w_r_rdy[i]        = S_AXI[i].r_ready;
        assign S_AXI[i].b_valid  = !i_rst && M_AXI.b_valid && (w_b_dst == IDX_W'(i));
        assign S_AXI[i].b_id     = M_AXI.b_id[AXI_ID_WIDTH-1:0];
        assign S_AXI[i].b_resp   = M_AXI.b_resp;
        assign S_AXI[i].b_user   = M_AXI.b_user;
        assign w_b_rdy[i]        = S_AXI[i].b_ready;
    end
    for (genvar i = N_PORTS; i < (1 << IDX_W); i++) begin : g_pad
        assign w_r_rdy[i] = 1'b1;
        assign w_b_rdy[i] = 1'b1;
    end
    rr_arbiter #(.N(N_PORTS), .IW(IDX_W)) u_ar_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (w_ar_req),
        .i_en  (!i_rst && r_ar_cnt != 4'(MAX_OUTSTANDING)),
        .i_adv (w_ar_hs),
        .o_gnt (w_ar_gnt),
        .o_idx (w_ar_idx)
    );
    rr_arbiter #(.N(N_PORTS), .IW(IDX_W)) u_aw_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (w_aw_req),
        .i_en  (!i_rst && r_wstate == WR_IDLE && r_aw_cnt != 4'(MAX_OUTSTANDING)),
        .i_adv (w_aw_hs),
        .o_gnt (w_aw_gnt),
        .o_idx (w_aw_idx)
    );
    assign M_AXI.ar_valid = |w_ar_gnt;
    assign M_AXI.ar_id    = {w_ar_idx, w_ar_id[w_ar_idx]};
    assign {M_AXI.ar_addr, M_AXI.ar_len, M_AXI.ar_size, M_AXI.ar_burst, M_AXI.ar_lock,
            M_AXI.ar_cache, M_AXI.ar_prot, M_AXI.ar_qos, M_AXI.ar_region, M_AXI.ar_user} = w_ar_pl[w_ar_idx];
    assign M_AXI.aw_valid = |w_aw_gnt;
    assign M_AXI.aw_id    = {w_aw_idx, w_aw_id[w_aw_idx]};
    assign {M_AXI.aw_addr, M_AXI.aw_len, M_AXI.aw_size, M_AXI.aw_burst, M_AXI.aw_lock,
            M_AXI.aw_cache, M_AXI.aw_prot, M_AXI.aw_qos, M_AXI.aw_region, M_AXI.aw_user} = w_aw_pl[w_aw_idx];
    assign M_AXI.w_valid  = w_w_open && w_w_vld[w_w_idx];
    assign {M_AXI.w_data, M_AXI.w_strb, M_AXI.w_user, M_AXI.w_last} = w_w_pl[w_w_idx];
    assign M_AXI.r_ready  = !i_rst && w_r_rdy[w_r_dst];
    assign M_AXI.b_ready  = !i_rst && w_b_rdy[w_b_dst];
    assign w_ar_hs = M_AXI.ar_valid && M_AXI.ar_ready;
    assign w_aw_hs = M_AXI.aw_valid && M_AXI.aw_ready;
    assign w_w_hs  = M_AXI.w_valid && M_AXI.w_ready;
    assign w_r_hs  = M_AXI.r_valid && M_AXI.r_ready;
    assign w_b_hs  = M_AXI.b_valid && M_AXI.b_ready;
    // outstanding counters per direction; a response with nothing outstanding is not counted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ar_cnt    <= '0;
            r_aw_cnt    <= '0;
            r_route_err <= 1'b0;
        end else begin
            r_ar_cnt    <= r_ar_cnt + 4'(w_ar_hs) - 4'(w_r_hs && M_AXI.r_last && (r_ar_cnt != 0 || w_ar_hs));
            r_aw_cnt    <= r_aw_cnt + 4'(w_aw_hs) - 4'(w_b_hs && (r_aw_cnt != 0 || w_aw_hs));
            r_route_err <= r_route_err || (w_r_hs && int'(w_r_dst) >= N_PORTS) || (w_b_hs && int'(w_b_dst) >= N_PORTS);
        end
    end
    // write data lock: W follows the AW winner until its last beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wstate  <= WR_IDLE;
            r_w_owner <= '0;
        end else if (r_wstate == WR_IDLE) begin
            if (w_aw_hs && !(w_w_hs && M_AXI.w_last)) begin
                r_wstate  <= WR_DATA;
                r_w_owner <= w_aw_idx;
            end
        end else if (w_w_hs && M_AXI.w_last) begin
            r_wstate <= WR_IDLE;
        end
    end
    a_no_route_err: assert property (@(posedge i_clk) disable iff (i_rst) !r_route_err);
endmodule

// File: tb/tb_axi4_cpu_port_arbiter.sv
// tb_axi4_cpu_port_arbiter: directed and randomized checks of arbitration, locking, limits and routing
module tb_axi4_cpu_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    axi4_if #(.ID_W(4)) s_if [2] ();
    axi4_if #(.ID_W(5)) m_if ();
    axi4_cpu_port_arbiter dut (.i_clk(clk), .i_rst(rst), .S_AXI(s_if), .M_AXI(m_if));
    logic [1:0]  s_arv, s_awv, s_wv, s_wl, s_rr, s_br;
    logic [3:0]  s_arid [2];
    logic [3:0]  s_awid [2];
    logic [31:0] s_araddr [2];
    logic [7:0]  s_awlen [2];
    logic [31:0] s_wd [2];
    logic [1:0]  s_arr, s_awr, s_wr, s_rv, s_bv;
    logic [3:0]  s_rid [2];
    logic [3:0]  s_bid [2];
    for (genvar g = 0; g < 2; g++) begin : g_s
        assign s_if[g].ar_valid  = s_arv[g];
        assign s_if[g].ar_id     = s_arid[g];
        assign s_if[g].ar_addr   = s_araddr[g];
        assign s_if[g].ar_len    = 8'd0;
        assign s_if[g].ar_size   = 3'd2;
        assign s_if[g].ar_burst  = 2'd1;
        assign s_if[g].ar_lock   = 1'b0;
        assign s_if[g].ar_cache  = 4'd0;
        assign s_if[g].ar_prot   = 3'd0;
        assign s_if[g].ar_qos    = 4'd0;
        assign s_if[g].ar_region = 4'd0;
        assign s_if[g].ar_user   = 1'b0;
        assign s_if[g].aw_valid  = s_awv[g];
        assign s_if[g].aw_id     = s_awid[g];
        assign s_if[g].aw_addr   = 32'h1000 * (g + 1);
        assign s_if[g].aw_len    = s_awlen[g];
        assign s_if[g].aw_size   = 3'd2;
        assign s_if[g].aw_burst  = 2'd1;
        assign s_if[g].aw_lock   = 1'b0;
        assign s_if[g].aw_cache  = 4'd0;
        assign s_if[g].aw_prot   = 3'd0;
        assign s_if[g].aw_qos    = 4'd0;
        assign s_if[g].aw_region = 4'd0;
        assign s_if[g].aw_user   = 1'b0;
        assign s_if[g].w_valid   = s_wv[g];
        assign s_if[g].w_data    = s_wd[g];
        assign s_if[g].w_strb    = 4'hF;
        assign s_if[g].w_last    = s_wl[g];
        assign s_if[g].w_user    = 1'b0;
        assign s_if[g].r_ready   = s_rr[g];
        assign s_if[g].b_ready   = s_br[g];
        assign s_arr[g] = s_if[g].ar_ready;
        assign s_awr[g] = s_if[g].aw_ready;
        assign s_wr[g]  = s_if[g].w_ready;
        assign s_rv[g]  = s_if[g].r_valid;
        assign s_bv[g]  = s_if[g].b_valid;
        assign s_rid[g] = s_if[g].r_id;
        assign s_bid[g] = s_if[g].b_id;
    end
    int n_chk, n_err;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int cnt, last, hidx, w, rp;
        bit held, exp_v, rv, hs;
        logic [3:0] rid;
        logic [31:0] d;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        s_arv = 2'b11; s_awv = 2'b11; s_wv = 2'b11; s_wl = 0; s_rr = 2'b11; s_br = 2'b11;
        for (int p = 0; p < 2; p++) begin
            s_arid[p] = 0; s_awid[p] = 0; s_araddr[p] = 0; s_awlen[p] = 0; s_wd[p] = 0;
        end
        m_if.ar_ready = 1; m_if.aw_ready = 1; m_if.w_ready = 1;
        m_if.r_valid = 1; m_if.r_id = 5'h10; m_if.r_data = 0; m_if.r_resp = 0; m_if.r_last = 1; m_if.r_user = 0;
        m_if.b_valid = 1; m_if.b_id = 5'h00; m_if.b_resp = 0; m_if.b_user = 0;
        #3;
        chk("rst_m_arvalid", m_if.ar_valid, 0);
        chk("rst_m_awvalid", m_if.aw_valid, 0);
        chk("rst_m_wvalid", m_if.w_valid, 0);
        chk("rst_s_arready", s_arr, 0);
        chk("rst_s_awready", s_awr, 0);
        chk("rst_s_wready", s_wr, 0);
        chk("rst_s_rvalid", s_rv, 0);
        chk("rst_s_bvalid", s_bv, 0);
        s_arv = 0; s_awv = 0; s_wv = 0; m_if.r_valid = 0; m_if.b_valid = 0;
        tick();
        rst = 1'b0;
        #4;
        chk("idle_m_arvalid", m_if.ar_valid, 0);
        chk("idle_m_awvalid", m_if.aw_valid, 0);
        tick();
        // round-robin reads
        s_arid[0] = 4'hA; s_arid[1] = 4'hB; s_arv = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("rr_arid", m_if.ar_id, (k % 2) ? 5'h1B : 5'h0A);
            chk("rr_arready", s_arr, (k % 2) ? 2'b10 : 2'b01);
            tick();
        end
        // four outstanding: a fifth request must wait
        s_arv = 2'b01;
        #4;
        chk("lim_m_arvalid", m_if.ar_valid, 0);
        chk("lim_s_arready", s_arr, 0);
        tick();
        m_if.r_valid = 1; m_if.r_id = 5'h13; m_if.r_last = 1; s_rr = 2'b10;
        #4;
        chk("route_r_valid", s_rv, 2'b10);
        chk("route_r_id", s_rid[1], 4'h3);
        chk("route_r_ready", m_if.r_ready, 1);
        chk("lim_still_blocked", m_if.ar_valid, 0);
        tick();
        m_if.r_valid = 0;
        #4;
        chk("lim_release_valid", m_if.ar_valid, 1);
        chk("lim_release_id", m_if.ar_id, 5'h0A);
        tick();
        s_arv = 0;
        m_if.r_valid = 1; m_if.r_id = 5'h07; s_rr = 2'b00;
        #4;
        chk("r_ready_follow", m_if.r_ready, 0);
        chk("r_valid_port0", s_rv, 2'b01);
        tick();
        s_rr = 2'b01;
        repeat (4) tick();
        m_if.r_valid = 0;
        // write lock: port 1 burst of 4 blocks port 0's AW
        s_awid[1] = 4'h6; s_awlen[1] = 8'd3; s_awv = 2'b10;
        #4;
        chk("wl_aw_id", m_if.aw_id, 5'h16);
        chk("wl_aw_len", m_if.aw_len, 3);
        chk("wl_aw_ready", s_awr, 2'b10);
        tick();
        s_awid[0] = 4'h2; s_awlen[0] = 8'd0; s_awv = 2'b01; s_awlen[1] = 8'd0;
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            s_wd[1] = d; s_wv = 2'b10; s_wl = (b == 3) ? 2'b10 : 2'b00;
            #4;
            chk("wl_blocked_awready", s_awr, 0);
            chk("wl_blocked_awvalid", m_if.aw_valid, 0);
            chk("wl_w_data", m_if.w_data, d);
            chk("wl_w_ready", s_wr, 2'b10);
            chk("wl_w_last", m_if.w_last, b == 3);
            tick();
        end
        s_wv = 2'b01; s_wl = 2'b01; s_wd[0] = 32'hCAFE0000;
        #4;
        chk("wl_next_aw_id", m_if.aw_id, 5'h02);
        chk("wl_next_awready", s_awr, 2'b01);
        chk("wl_same_cycle_w", s_wr, 2'b01);
        tick();
        s_wv = 0; s_wl = 0; s_awv = 2'b10;
        #4;
        chk("wl_stays_idle", m_if.aw_valid, 1);
        chk("wl_stays_idle_id", m_if.aw_id, 5'h16);
        tick();
        // stall in DATA, then response routing on B
        s_awv = 2'b01; m_if.aw_ready = 0; m_if.w_ready = 0; s_wv = 2'b10; s_wl = 2'b10;
        m_if.b_valid = 1; m_if.b_id = 5'h05; s_br = 2'b01;
        #4;
        chk("data_blocks_aw", m_if.aw_valid, 0);
        chk("data_w_live", m_if.w_valid, 1);
        chk("route_b_valid", s_bv, 2'b01);
        chk("route_b_id", s_bid[0], 4'h5);
        chk("route_b_ready", m_if.b_ready, 1);
        tick();
        m_if.b_valid = 0;
        rst = 1'b1;
        #1;
        chk("arst_m_wvalid", m_if.w_valid, 0);
        chk("arst_s_wready", s_wr, 0);
        chk("arst_m_awvalid", m_if.aw_valid, 0);
        chk("arst_s_awready", s_awr, 0);
        tick();
        rst = 1'b0; m_if.aw_ready = 1; m_if.w_ready = 1; s_wv = 0; s_wl = 0;
        #4;
        chk("post_rst_aw_valid", m_if.aw_valid, 1);
        chk("post_rst_aw_id", m_if.aw_id, 5'h02);
        tick();
        s_awv = 0; s_wv = 2'b01; s_wl = 2'b01;
        tick();
        s_wv = 0; s_wl = 0;
        // randomized reads against a counting model
        cnt = 0; last = 1; held = 0; hidx = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!s_arv[p] && $urandom_range(0, 1) == 1) begin
                    s_arv[p] = 1'b1; s_arid[p] = 4'($urandom); s_araddr[p] = $urandom;
                end
            end
            m_if.ar_ready = $urandom_range(0, 3) != 0;
            rv = cnt > 0 && $urandom_range(0, 2) == 0;
            rp = $urandom_range(0, 1);
            rid = 4'($urandom);
            m_if.r_valid = rv; m_if.r_id = {rp[0], rid}; m_if.r_last = 1'($urandom); s_rr = 2'($urandom);
            #4;
            exp_v = s_arv != 0 && cnt < 4;
            w = -1;
            if (held) w = hidx;
            else for (int k = 1; k <= 2; k++) if (w < 0 && s_arv[(last + k) % 2]) w = (last + k) % 2;
            chk("rnd_ar_valid", m_if.ar_valid, exp_v);
            if (exp_v) begin
                chk("rnd_ar_id", m_if.ar_id, {w[0], s_arid[w]});
                chk("rnd_ar_addr", m_if.ar_addr, s_araddr[w]);
            end
            chk("rnd_ar_ready", s_arr, (exp_v && m_if.ar_ready) ? (2'b01 << w) : 2'b00);
            chk("rnd_r_valid", s_rv, rv ? (2'b01 << rp) : 2'b00);
            if (rv) begin
                chk("rnd_r_id", s_rid[rp], rid);
                chk("rnd_r_ready", m_if.r_ready, s_rr[rp]);
            end
            hs = exp_v && m_if.ar_ready;
            if (rv && s_rr[rp] && m_if.r_last) cnt--;
            if (hs) begin
                cnt++; last = w;
            end
            held = exp_v && !hs;
            hidx = w;
            tick();
            if (hs) s_arv[w] = 1'b0;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
